// File: rtl/cafu_log_pkg.sv
// Shared widths and helpers for the CAFU stream logger.
package cafu_log_pkg;

    localparam int unsigned ENTRY_W          = 72;
    localparam int unsigned LINE_W           = 512;
    localparam int unsigned ENTRIES_PER_LINE = 7;
    localparam int unsigned LINE_BYTES       = 64;
    localparam int unsigned ID_W             = 5;
    localparam int unsigned AXI_ID_W         = 12;

    typedef logic [ID_W-1:0] id_t;

    // Ring slot address; the 64-bit add wraps naturally.
    function automatic logic [63:0] line_addr(input logic [63:0] base, input logic [63:0] idx);
        return base + (idx << $clog2(LINE_BYTES));
    endfunction

endpackage

// File: rtl/cafu_log_id_pool.sv
// Outstanding AXI write-ID tracker: taken bitmap, lowest-free allocation, free on response.
module cafu_log_id_pool
    import cafu_log_pkg::*;
#(
    parameter int unsigned NUM_IDS = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic alloc_i,
    input  logic free_i,
    input  id_t  free_id_i,
    output id_t  alloc_id_o,
    output logic any_free_o
);

    logic [NUM_IDS-1:0] taken_q, taken_d;

    always_comb begin
        alloc_id_o = '0;
        for (int unsigned i = NUM_IDS; i > 0; i--) begin
            if (!taken_q[i-1]) begin
                alloc_id_o = id_t'(i - 1);
            end
        end
    end

    assign any_free_o = ~&taken_q;

    // Free is applied before allocation so both take effect in the same cycle.
    always_comb begin
        taken_d = taken_q;
        if (free_i) begin
            taken_d[free_id_i] = 1'b0;
        end
        if (alloc_i && any_free_o) begin
            taken_d[alloc_id_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_q <= '0;
        end else begin
            taken_q <= taken_d;
        end
    end

endmodule

// File: rtl/cafu_log.sv
// Stream-to-memory logger: packs th0 stream entries into 64-byte lines and
// writes each line to a host ring with a single-beat AXI4 write.
module cafu_log #(
    parameter int unsigned ENTRIES_PER_LINE = cafu_log_pkg::ENTRIES_PER_LINE,
    parameter int unsigned NUM_IDS          = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [3:0]   log_operation_mode,
    input  logic [5:0]   log_awuser_reg,
    input  logic [63:0]  log_write_base_addr,
    output logic [63:0]  stat_h0,
    output logic [63:0]  stat_h1,
    output logic [63:0]  stat_d0,
    output logic [63:0]  stat_d1,
    output logic [11:0]  awid,
    output logic [63:0]  awaddr,
    output logic [5:0]   awuser,
    output logic         awvalid,
    input  logic         awready,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [11:0]  bid,
    input  logic [1:0]   bresp,
    input  logic [3:0]   buser,
    input  logic         bvalid,
    output logic         bready,
    input  logic         ip2cafu_axisth0_tvalid,
    input  logic [71:0]  ip2cafu_axisth0_tdata,
    output logic         cafu2ip_axisth0_tready
);

    import cafu_log_pkg::*;

    localparam int unsigned       FILL_W    = $clog2(ENTRIES_PER_LINE + 1);
    localparam int unsigned       PACK_W    = ENTRIES_PER_LINE * ENTRY_W;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(ENTRIES_PER_LINE);

    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PACK_W-1:0] buf_q, buf_d;
    logic [63:0]       line_idx_q, line_idx_d;
    logic              issued_q, issued_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    id_t               awid_q, awid_d;
    logic [63:0]       awaddr_q, awaddr_d;
    logic [63:0]       h0_q, h0_d;
    logic [63:0]       h1_q, h1_d;
    logic [63:0]       d0_q, d0_d;

    logic full, accept, issue, aw_hs, w_hs, release_line;
    logic any_free;
    id_t  alloc_id;
    logic unused_b;

    assign full         = (fill_q == FILL_FULL);
    assign cafu2ip_axisth0_tready = (log_operation_mode == 4'd1) && !full;
    assign accept       = ip2cafu_axisth0_tvalid && cafu2ip_axisth0_tready;
    assign issue        = full && !issued_q && any_free;
    assign aw_hs        = awvalid_q && awready;
    assign w_hs         = wvalid_q && wready;
    // Line is released on the edge where the last outstanding handshake lands.
    assign release_line = issued_q && (!awvalid_q || awready) && (!wvalid_q || wready);

    cafu_log_id_pool #(
        .NUM_IDS (NUM_IDS)
    ) u_pool (
        .clk_i      (clk),
        .rst_i      (rstn),
        .alloc_i    (issue),
        .free_i     (bvalid),
        .free_id_i  (bid[ID_W-1:0]),
        .alloc_id_o (alloc_id),
        .any_free_o (any_free)
    );

    always_comb begin
        fill_d     = fill_q;
        buf_d      = buf_q;
        line_idx_d = line_idx_q;
        issued_d   = issued_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        awid_d     = awid_q;
        awaddr_d   = awaddr_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        d0_d       = d0_q;

        if (accept) begin
            for (int unsigned k = 0; k < ENTRIES_PER_LINE; k++) begin
                if (fill_q == FILL_W'(k)) begin
                    buf_d[k*ENTRY_W +: ENTRY_W] = ip2cafu_axisth0_tdata;
                end
            end
            fill_d = fill_q + 1'b1;
            h0_d   = h0_q + 64'd1;
        end

        if (issue) begin
            issued_d  = 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awid_d    = alloc_id;
            awaddr_d  = line_addr(log_write_base_addr, line_idx_q);
        end else begin
            if (aw_hs) begin
                awvalid_d = 1'b0;
            end
            if (w_hs) begin
                wvalid_d = 1'b0;
            end
        end

        if (release_line) begin
            issued_d   = 1'b0;
            fill_d     = '0;
            line_idx_d = line_idx_q + 64'd1;
        end

        if (aw_hs) begin
            h1_d = h1_q + 64'd1;
        end
        if (bvalid) begin
            d0_d = d0_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            fill_q     <= '0;
            buf_q      <= '0;
            line_idx_q <= '0;
            issued_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            awid_q     <= '0;
            awaddr_q   <= '0;
            h0_q       <= '0;
            h1_q       <= '0;
            d0_q       <= '0;
        end else begin
            fill_q     <= fill_d;
            buf_q      <= buf_d;
            line_idx_q <= line_idx_d;
            issued_q   <= issued_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            awid_q     <= awid_d;
            awaddr_q   <= awaddr_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            d0_q       <= d0_d;
        end
    end

    assign awid     = {{(AXI_ID_W - ID_W){1'b0}}, awid_q};
    assign awaddr   = awaddr_q;
    assign awuser   = log_awuser_reg;
    assign awvalid  = awvalid_q;
    assign wdata    = {{(LINE_W - PACK_W){1'b0}}, buf_q};
    assign wstrb    = '1;
    assign wlast    = 1'b1;
    assign wvalid   = wvalid_q;
    assign bready   = 1'b1;
    assign stat_h0  = h0_q;
    assign stat_h1  = h1_q;
    assign stat_d0  = d0_q;
    assign stat_d1  = h1_q - d0_q;

    assign unused_b = ^{bresp, buser, bid[AXI_ID_W-1:ID_W]};

endmodule

// File: tb/tb_cafu_log.sv
// Scoreboard bench for cafu_log: expected lines queued as entries are accepted, compared as AXI writes appear.
`timescale 1ns/1ps
module tb_cafu_log;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [3:0]   mode = '0;
    logic [5:0]   awuser_reg = 6'h2a;
    logic [63:0]  base = '0;
    logic [63:0]  stat_h0, stat_h1, stat_d0, stat_d1;
    logic [11:0]  awid;
    logic [63:0]  awaddr;
    logic [5:0]   awuser;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid;
    logic         wready = 1'b0;
    logic [11:0]  bid = '0;
    logic [1:0]   bresp = '0;
    logic [3:0]   buser = '0;
    logic         bvalid = 1'b0;
    logic         bready;
    logic         tvalid = 1'b0;
    logic [71:0]  tdata = '0;
    logic         tready;

    always #5 clk = ~clk;

    cafu_log dut (
        .clk(clk), .rstn(rstn), .log_operation_mode(mode), .log_awuser_reg(awuser_reg),
        .log_write_base_addr(base), .stat_h0(stat_h0), .stat_h1(stat_h1), .stat_d0(stat_d0),
        .stat_d1(stat_d1), .awid(awid), .awaddr(awaddr), .awuser(awuser), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid),
        .bready(bready), .ip2cafu_axisth0_tvalid(tvalid), .ip2cafu_axisth0_tdata(tdata),
        .cafu2ip_axisth0_tready(tready)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard (owned by the test tasks)
    logic [511:0] exp_data[$];
    logic [63:0]  exp_addr[$];
    logic [511:0] part = '0;
    int           part_n = 0;
    logic [63:0]  exp_idx = '0;
    logic [71:0]  next_val = '0;

    // Observed traffic and responder state (owned by the monitor)
    logic [511:0] obs_data[$];
    logic [63:0]  obs_addr[$];
    logic [11:0]  obs_id[$];
    int           pending[$];
    int           manual_b[$];
    logic [31:0]  outstanding = '0;
    int           reuse_err = 0;
    int           aw_stall = 0;
    int           w_stall = 0;
    int           b_idx, b_id;

    int   rdy_mode = 0;   // 0 always ready, 1 random stalls, 2 forced
    int   b_mode = 0;     // 0 withhold, 1 immediate in order, 2 random order
    logic aw_force = 1'b0;
    logic w_force = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            bvalid = 1'b0; bid = '0; awready = 1'b0; wready = 1'b0;
            pending.delete(); obs_data.delete(); obs_addr.delete(); obs_id.delete();
            outstanding = '0; aw_stall = 0; w_stall = 0; reuse_err = 0;
        end else begin
            bvalid = 1'b0;
            bid    = '0;
            if (manual_b.size() > 0) begin
                b_id = manual_b.pop_front();
                bvalid = 1'b1; bid = 12'(b_id); outstanding[b_id] = 1'b0;
            end else if (pending.size() > 0 && (b_mode == 1 || (b_mode == 2 && $urandom_range(0, 1) == 1))) begin
                b_idx = (b_mode == 2) ? int'($urandom_range(0, pending.size() - 1)) : 0;
                b_id  = pending[b_idx];
                pending.delete(b_idx);
                bvalid = 1'b1; bid = 12'(b_id); outstanding[b_id] = 1'b0;
            end
            case (rdy_mode)
                1: begin
                    awready = (aw_stall == 0);
                    if (aw_stall > 0) aw_stall--;
                    wready = (w_stall == 0);
                    if (w_stall > 0) w_stall--;
                end
                2: begin
                    awready = aw_force;
                    wready  = w_force;
                end
                default: begin
                    awready = 1'b1;
                    wready  = 1'b1;
                end
            endcase
            if (awvalid && awready) begin
                if (outstanding[awid[4:0]]) reuse_err++;
                outstanding[awid[4:0]] = 1'b1;
                pending.push_back(int'(awid[4:0]));
                obs_addr.push_back(awaddr);
                obs_id.push_back(awid);
                if (rdy_mode == 1) aw_stall = $urandom_range(0, 24);
            end
            if (wvalid && wready) begin
                obs_data.push_back(wdata);
                if (rdy_mode == 1) w_stall = $urandom_range(0, 6);
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b1; tvalid = 1'b0; tdata = '0; mode = '0;
        exp_data.delete(); exp_addr.delete(); manual_b.delete();
        part = '0; part_n = 0; exp_idx = '0; next_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic sb_push(input logic [71:0] v);
        part[part_n*72 +: 72] = v;
        part_n++;
        if (part_n == 7) begin
            exp_data.push_back(part);
            exp_addr.push_back(base + (exp_idx * 64'd64));
            exp_idx++;
            part_n = 0;
            part = '0;
        end
    endtask

    task automatic send_n(input int n, input bit gaps, input int limit, output int got);
        int cyc = 0;
        got = 0;
        while (got < n && cyc < limit) begin
            @(negedge clk);
            tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tdata  = next_val;
            #1;
            if (tvalid && tready) begin
                sb_push(next_val);
                next_val++;
                got++;
            end
            cyc++;
        end
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int limit, output bit ok);
        int cyc = 0;
        while ((obs_addr.size() < n || obs_data.size() < n) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        ok = (obs_addr.size() >= n && obs_data.size() >= n);
    endtask

    task automatic wait_idle(input int limit);
        int cyc = 0;
        while (pending.size() > 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        int cyc = 0;
        while (!awvalid && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        ok = awvalid;
    endtask

    task automatic test_reset();
        do_reset();
        rdy_mode = 0; b_mode = 1; mode = 4'd0;
        #1;
        checks++; if ({stat_h0, stat_h1, stat_d0, stat_d1} !== '0) begin errors++; $display("FAIL reset_stats got=%h/%h/%h/%h required=0", stat_h0, stat_h1, stat_d0, stat_d1); end
        checks++; if (wstrb !== '1 || wlast !== 1'b1 || bready !== 1'b1) begin errors++; $display("FAIL const_outputs wstrb=%h wlast=%b bready=%b required=all-ones/1/1", wstrb, wlast, bready); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tvalid = 1'b1; tdata = 72'(i);
            #1;
            checks++; if (tready !== 1'b0) begin errors++; $display("FAIL mode0_tready cycle=%0d got=%b required=0", i, tready); end
            checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL mode0_valid cycle=%0d got=%b%b required=00", i, awvalid, wvalid); end
        end
        tvalid = 1'b0;
        checks++; if (stat_h0 !== 64'd0) begin errors++; $display("FAIL mode0_h0 got=%0d required=0", stat_h0); end
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL mode0_writes got=%0d required=0", obs_addr.size()); end
    endtask

    task automatic test_stream();
        int got; bit ok; int ln = 0;
        logic [511:0] l0, ed, od; logic [63:0] ea, oa;
        do_reset();
        base = 64'hbeefdead00000000; mode = 4'd1; rdy_mode = 0; b_mode = 1;
        send_n(448, 1'b0, 4000, got);
        checks++; if (got != 448) begin errors++; $display("FAIL stream_accept got=%0d required=448", got); end
        wait_obs(64, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got=%0d required=64 lines", obs_addr.size()); end
        if (ok) begin
            l0 = obs_data[0];
            checks++; if (l0[71:0] !== 72'd0 || l0[503:432] !== 72'd6 || l0[511:504] !== 8'd0) begin errors++; $display("FAIL line0_fields got=%h/%h/%h required=0/6/0", l0[71:0], l0[503:432], l0[511:504]); end
            checks++; if (obs_addr[63] !== 64'hbeefdead00000fc0) begin errors++; $display("FAIL last_addr got=%h required=beefdead00000fc0", obs_addr[63]); end
        end
        while (exp_addr.size() > 0 && obs_addr.size() > 0 && obs_data.size() > 0) begin
            ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
            checks++; if (oa !== ea) begin errors++; $display("FAIL stream_addr line=%0d got=%h required=%h", ln, oa, ea); end
            checks++; if (od !== ed) begin errors++; $display("FAIL stream_data line=%0d got=%h required=%h", ln, od, ed); end
            ln++;
        end
        wait_idle(500);
        checks++; if (stat_h0 !== 64'd448 || stat_h1 !== 64'd64 || stat_d0 !== 64'd64 || stat_d1 !== 64'd0) begin errors++; $display("FAIL stream_stats got=%0d/%0d/%0d/%0d required=448/64/64/0", stat_h0, stat_h1, stat_d0, stat_d1); end
        checks++; if (awuser !== 6'h2a) begin errors++; $display("FAIL awuser got=%h required=2a", awuser); end
    endtask

    task automatic test_random_stalls();
        int got; bit ok; int ln = 0;
        logic [511:0] ed, od; logic [63:0] ea, oa;
        do_reset();
        base = 64'hffffffff_fffff800; mode = 4'd1; rdy_mode = 1; b_mode = 2;
        send_n(448, 1'b1, 20000, got);
        checks++; if (got != 448) begin errors++; $display("FAIL rand_accept got=%0d required=448", got); end
        wait_obs(64, 5000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got=%0d required=64 lines", obs_addr.size()); end
        while (exp_addr.size() > 0 && obs_addr.size() > 0 && obs_data.size() > 0) begin
            ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
            checks++; if (oa !== ea) begin errors++; $display("FAIL rand_addr line=%0d got=%h required=%h", ln, oa, ea); end
            checks++; if (od !== ed) begin errors++; $display("FAIL rand_data line=%0d got=%h required=%h", ln, od, ed); end
            ln++;
        end
        wait_idle(5000);
        checks++; if (reuse_err != 0) begin errors++; $display("FAIL id_reuse got=%0d required=0", reuse_err); end
        checks++; if (dut.u_pool.taken_q !== 32'd0) begin errors++; $display("FAIL bitmap_empty got=%h required=0", dut.u_pool.taken_q); end
        checks++; if (stat_h1 !== 64'd64 || stat_d1 !== 64'd0) begin errors++; $display("FAIL rand_stats got=%0d/%0d required=64/0", stat_h1, stat_d1); end
    endtask

    task automatic test_no_bresp();
        int got; bit ok; int ln = 0;
        logic [511:0] ed, od; logic [63:0] ea, oa;
        do_reset();
        base = 64'h0000_0000_0001_0000; mode = 4'd1; rdy_mode = 0; b_mode = 0;
        send_n(231, 1'b0, 3000, got);
        checks++; if (got != 231) begin errors++; $display("FAIL nob_accept got=%0d required=231", got); end
        wait_obs(32, 500, ok);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (obs_id.size() != 32) begin errors++; $display("FAIL nob_count got=%0d required=32", obs_id.size()); end
        if (ok) begin
            for (int i = 0; i < 32; i++) begin
                checks++; if (obs_id[i] !== 12'(i)) begin errors++; $display("FAIL nob_awid line=%0d got=%0d required=%0d", i, obs_id[i], i); end
            end
        end
        checks++; if (tready !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("FAIL nob_stall tready=%b awvalid=%b required=0/0", tready, awvalid); end
        manual_b.push_back(5);
        wait_obs(33, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nob_resume got=%0d required=33 lines", obs_addr.size()); end
        if (ok) begin
            checks++; if (obs_id[32] !== 12'd5) begin errors++; $display("FAIL nob_reuse5 got=%0d required=5", obs_id[32]); end
        end
        while (exp_addr.size() > 0 && obs_addr.size() > 0 && obs_data.size() > 0) begin
            ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
            checks++; if (oa !== ea) begin errors++; $display("FAIL nob_addr line=%0d got=%h required=%h", ln, oa, ea); end
            checks++; if (od !== ed) begin errors++; $display("FAIL nob_data line=%0d got=%h required=%h", ln, od, ed); end
            ln++;
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stat_h0 !== 64'd231 || stat_h1 !== 64'd33 || stat_d0 !== 64'd1 || stat_d1 !== 64'd32) begin errors++; $display("FAIL nob_stats got=%0d/%0d/%0d/%0d required=231/33/1/32", stat_h0, stat_h1, stat_d0, stat_d1); end
    endtask

    task automatic test_aw_w_skew();
        int got; bit ok; int ln = 0;
        logic [511:0] ed, od; logic [63:0] ea, oa;
        do_reset();
        base = 64'h0000_0000_0000_2000; mode = 4'd1; rdy_mode = 2; b_mode = 1;
        aw_force = 1'b0; w_force = 1'b0;
        // AW completes first
        send_n(7, 1'b0, 100, got);
        wait_valid(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL skew1_issue got=%b required=1", awvalid); end
        @(posedge clk); #2; aw_force = 1'b1;
        @(posedge clk); #2; aw_force = 1'b0;
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || tready !== 1'b0) begin errors++; $display("FAIL skew1_aw got=%b%b%b required=010", awvalid, wvalid, tready); end
        repeat (3) begin
            @(posedge clk); #2;
            checks++; if (tready !== 1'b0 || wvalid !== 1'b1) begin errors++; $display("FAIL skew1_hold tready=%b wvalid=%b required=0/1", tready, wvalid); end
        end
        w_force = 1'b1;
        @(posedge clk); #2; w_force = 1'b0;
        checks++; if (wvalid !== 1'b0 || tready !== 1'b1) begin errors++; $display("FAIL skew1_release wvalid=%b tready=%b required=0/1", wvalid, tready); end
        // W completes first
        send_n(7, 1'b0, 100, got);
        wait_valid(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL skew2_issue got=%b required=1", awvalid); end
        @(posedge clk); #2; w_force = 1'b1;
        @(posedge clk); #2; w_force = 1'b0;
        checks++; if (awvalid !== 1'b1 || wvalid !== 1'b0 || tready !== 1'b0) begin errors++; $display("FAIL skew2_w got=%b%b%b required=100", awvalid, wvalid, tready); end
        repeat (3) begin
            @(posedge clk); #2;
            checks++; if (tready !== 1'b0 || awvalid !== 1'b1) begin errors++; $display("FAIL skew2_hold tready=%b awvalid=%b required=0/1", tready, awvalid); end
        end
        aw_force = 1'b1;
        @(posedge clk); #2; aw_force = 1'b0;
        checks++; if (awvalid !== 1'b0 || tready !== 1'b1) begin errors++; $display("FAIL skew2_release awvalid=%b tready=%b required=0/1", awvalid, tready); end
        rdy_mode = 0;
        send_n(7, 1'b0, 100, got);
        wait_obs(3, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL skew_timeout got=%0d required=3 lines", obs_addr.size()); end
        while (exp_addr.size() > 0 && obs_addr.size() > 0 && obs_data.size() > 0) begin
            ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
            checks++; if (oa !== ea) begin errors++; $display("FAIL skew_addr line=%0d got=%h required=%h", ln, oa, ea); end
            checks++; if (od !== ed) begin errors++; $display("FAIL skew_data line=%0d got=%h required=%h", ln, od, ed); end
            ln++;
        end
        wait_idle(100);
        checks++; if (stat_h1 !== 64'd3 || stat_d0 !== 64'd3) begin errors++; $display("FAIL skew_stats got=%0d/%0d required=3/3", stat_h1, stat_d0); end
    endtask

    task automatic test_mode_toggle();
        int got; bit ok; int ln = 0;
        logic [511:0] ed, od; logic [63:0] ea, oa;
        do_reset();
        base = 64'h0000_0000_0000_3000; mode = 4'd1; rdy_mode = 0; b_mode = 1;
        send_n(3, 1'b0, 50, got);
        mode = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tvalid = 1'b1; tdata = next_val;
            #1;
            checks++; if (tready !== 1'b0) begin errors++; $display("FAIL toggle_tready cycle=%0d got=%b required=0", i, tready); end
        end
        tvalid = 1'b0;
        mode = 4'd1;
        send_n(3, 1'b0, 50, got);
        repeat (5) @(negedge clk);
        #1;
        checks++; if (obs_addr.size() != 0 || awvalid !== 1'b0) begin errors++; $display("FAIL toggle_early got=%0d/%b required=0/0", obs_addr.size(), awvalid); end
        send_n(1, 1'b0, 50, got);
        mode = 4'd0;
        wait_obs(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL toggle_inflight got=%0d required=1 line", obs_addr.size()); end
        mode = 4'd1;
        send_n(7, 1'b0, 100, got);
        wait_obs(2, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout got=%0d required=2 lines", obs_addr.size()); end
        while (exp_addr.size() > 0 && obs_addr.size() > 0 && obs_data.size() > 0) begin
            ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
            checks++; if (oa !== ea) begin errors++; $display("FAIL toggle_addr line=%0d got=%h required=%h", ln, oa, ea); end
            checks++; if (od !== ed) begin errors++; $display("FAIL toggle_data line=%0d got=%h required=%h", ln, od, ed); end
            ln++;
        end
        checks++; if (stat_h0 !== 64'd14) begin errors++; $display("FAIL toggle_h0 got=%0d required=14", stat_h0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_random_stalls();
        test_no_bresp();
        test_aw_w_skew();
        test_mode_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cafu_log.md
Name: cafu_log

Overview:
- Stream-to-memory logger inside the CAFU.
- Captures 72-bit entries from the host-side AXI-Stream channel th0 and packs 7 entries into one 64-byte line.
- Writes each line to a host memory ring with single-beat AXI4 writes, starting at a programmable base address.
- Tracks outstanding write IDs and exports activity counters.

Parameters:
- ENTRIES_PER_LINE, 7, stream entries packed per 512-bit line.
- NUM_IDS, 32, outstanding AXI write IDs; width of the ID pool bitmap.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-high (1 = reset).
- log_operation_mode  in  4  1 = logging enabled; any other value = disabled.
- log_awuser_reg  in  6  value driven on awuser.
- log_write_base_addr  in  64  byte address of line 0.
- stat_h0  out  64  count of stream entries accepted.
- stat_h1  out  64  count of AW handshakes (lines issued).
- stat_d0  out  64  count of B handshakes.
- stat_d1  out  64  count of outstanding writes (stat_h1 - stat_d0).
- awid  out  12  write ID; bits [4:0] carry the ID, bits [11:5] are 0.
- awaddr  out  64  line address.
- awuser  out  6  = log_awuser_reg.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- wdata  out  512  packed line.
- wstrb  out  64  all ones.
- wlast  out  1  constant 1.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- bid  in  12  response ID; bits [4:0] used.
- bresp  in  2  ignored.
- buser  in  4  ignored.
- bvalid  in  1  B valid.
- bready  out  1  constant 1.
- ip2cafu_axisth0_tvalid  in  1  entry valid.
- ip2cafu_axisth0_tdata  in  72  entry.
- cafu2ip_axisth0_tready  out  1  entry ready.

Behaviour:
- Reset (rstn=1 at a clk edge): clears fill count, line_index, ID bitmap, all stat counters, awvalid, wvalid and the line buffer. Any partial line is dropped.
- Packing: entry k (0..6) of a line goes to wdata[72k+71:72k]. wdata[511:504] = 0. Entry 0 is the first entry accepted after the previous line was released.
- Accept: tready = (mode==1) && (fill<7). An entry is accepted on a clk edge with tvalid && tready; fill increments and stat_h0 increments.
- Issue: when fill reaches 7 and the ID pool has a free ID, on the next edge:
  - allocate the lowest free ID and mark it taken;
  - latch awid and awaddr = log_write_base_addr + line_index*64 (64-bit add, wraps mod 2^64);
  - assert awvalid and wvalid together.
  - If no ID is free, hold and retry every cycle.
- AW and W handshakes are independent and may complete in either order or in the same cycle. Each valid deasserts on the edge after its own handshake and holds until then; awaddr, awid and wdata stay stable while valid.
- Release: the edge on which the second of the two handshakes completes (or both in the same cycle) sets fill=0 and line_index+1. tready therefore rises the following cycle.
- Minimum latency: 7th entry accepted at edge N → awvalid/wvalid high after edge N+1.
- Responses: bready is always 1. bvalid at an edge frees bid[4:0] in the bitmap and increments stat_d0.
  - A free and an allocation in the same cycle both take effect.
  - A freed ID is allocatable in the next cycle.
  - A response whose ID is not taken is counted but has no other effect.
- Mode: mode≠1 deasserts tready only.
  - A partial line is retained and resumes when mode returns to 1.
  - An already-issued line completes normally.
  - Mode does not clear line_index.
- stat counters are 64-bit wrapping.

Decomposition:
- Package cafu_log_pkg: ENTRY_W=72, LINE_W=512, ENTRIES_PER_LINE=7, LINE_BYTES=64, ID_W=5, AXI_ID_W=12.
- One sub-module, cafu_log_id_pool: 32-bit taken bitmap with alloc (lowest-free priority encoder), free, and any_free outputs.

Test Plan:
- Reset, mode=0, tvalid=1 for 100 cycles → tready=0, no AW/W, all stats 0.
- Mode=1, base=0xbeefdead00000000, data counting 0..447, awready/wready always 1, immediate B →
  - 64 writes at awaddr base+0x00, +0x40, … +0xFC0;
  - line 0 wdata[71:0]=0 … [503:432]=6, [511:504]=0;
  - stat_h0=448, stat_h1=stat_d0=64, stat_d1=0.
- Random awready/wready stalls (0–24 and 0–6 cycles) with random-order B responses → same data/address sequence; no ID is reused while outstanding; final bitmap empty.
- Withhold all B responses → exactly 32 lines issued with awid 0..31, then stall with tready=0. Return bid=5 → next line uses awid 5.
- AW handshake 3 cycles before W, and the reverse → fill clears only after both; single line, single index increment.
- Mode 1→0 after 3 entries, then back to 1 → line contains entries 0..6 contiguous; no write until the 7th entry.
